// File: rtl/prau_quire_spill.sv
// PRAU quire spill/fill engine: streams a quire snapshot out as XLEN-bit beats (SAVE)
// and reassembles XLEN-bit beats into a single quire write (RESTORE). Build option: PRAU_QUIRE_SPILL_CHECKSUM_EN.
module prau_quire_spill #(
    parameter int XLEN     = 64,
    parameter int QUIRELEN = 512
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_op_i,
    input  logic [QUIRELEN-1:0] quire_i,
    output logic [QUIRELEN-1:0] quire_o,
    output logic                quire_we_o,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [XLEN-1:0]     rd_data_o,
    output logic                rd_last_o,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                wr_last_i,
    output logic                busy_o,
    output logic                err_o
);
    localparam int NBEATS = QUIRELEN / XLEN;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
    localparam int NTOT = NBEATS + 1;
`else
    localparam int NTOT = NBEATS;
`endif
    localparam int CW = $clog2(NTOT + 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, COMMIT} state_t;

    state_t              state;
    logic [QUIRELEN-1:0] sbuf;
    logic [CW-1:0]       count;
    logic                last_beat;
    logic [QUIRELEN-1:0] shifted_in;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
    logic [XLEN-1:0]     csum;
`endif

    assign last_beat   = (count == CW'(NTOT - 1));
    assign shifted_in  = {wr_data_i, sbuf[QUIRELEN-1:XLEN]};
    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rd_valid_o  = (state == SAVE);
    assign wr_ready_o  = (state == RESTORE);
    assign rd_last_o   = (state == SAVE) && last_beat;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
    // The trailing beat carries the XOR of every data beat already sent.
    assign rd_data_o   = (state != SAVE)          ? '0   :
                         (count == CW'(NBEATS))   ? csum : sbuf[XLEN-1:0];
`else
    assign rd_data_o   = (state == SAVE) ? sbuf[XLEN-1:0] : '0;
`endif

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            sbuf       <= '0;
            count      <= '0;
            quire_o    <= '0;
            quire_we_o <= 1'b0;
            err_o      <= 1'b0;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            // NOTE: the write strobe defaults low every cycle, so it can only ever be a one-cycle pulse.
            quire_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        err_o <= 1'b0;
                        count <= '0;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
                        csum  <= '0;
`endif
                        if (req_op_i) begin
                            sbuf  <= '0;
                            state <= RESTORE;
                        end else begin
                            sbuf  <= quire_i;
                            state <= SAVE;
                        end
                    end
                end
                SAVE: begin
                    if (rd_ready_i) begin
                        if (last_beat) begin
                            count <= '0;
                            state <= IDLE;
                        end else begin
                            sbuf  <= sbuf >> XLEN;
                            count <= count + 1'b1;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
                            csum  <= csum ^ sbuf[XLEN-1:0];
`endif
                        end
                    end
                end
                RESTORE: begin
                    if (wr_valid_i) begin
                        if (wr_last_i != last_beat) begin
                            err_o <= 1'b1;
                            sbuf  <= '0;
                            count <= '0;
                            state <= IDLE;
                        end else if (last_beat) begin
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
                            if (wr_data_i != csum) begin
                                err_o <= 1'b1;
                                sbuf  <= '0;
                                count <= '0;
                                state <= IDLE;
                            end else begin
                                quire_o    <= sbuf;
                                quire_we_o <= 1'b1;
                                state      <= COMMIT;
                            end
`else
                            quire_o    <= shifted_in;
                            quire_we_o <= 1'b1;
                            state      <= COMMIT;
`endif
                        end else begin
                            sbuf  <= shifted_in;
                            count <= count + 1'b1;
`ifdef PRAU_QUIRE_SPILL_CHECKSUM_EN
                            csum  <= csum ^ wr_data_i;
`endif
                        end
                    end
                end
                COMMIT: begin
                    count <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
